serial_add_ctrl: RTL

- Bit-serial N-bit adder controller. Sequences one shared 1-bit full-adder slice, built from two existing `halfadd` instances plus an OR gate, over WIDTH clock cycles, LSB first.
- Captures operands on a start request, holds the carry between bits, assembles the sum, and reports completion with a one-cycle done pulse.
- Sits between a requesting master and the half-adder datapath as the area-minimal alternative to a ripple adder.

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half adders + OR)
// is stepped across the operands LSB first, one bit per clock.

module halfadd (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse from
  // which sum/cout are valid, and they hold until the next completed operation.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             ha1_s, ha1_c, ha2_c;
  logic             bit_s, bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] part_shift;

  halfadd u_ha1 (.a(a_q[0]), .b(b_q[0]),  .sum(ha1_s), .carry(ha1_c));
  halfadd u_ha2 (.a(ha1_s),  .b(carry_q), .sum(bit_s), .carry(ha2_c));

  assign bit_c    = ha1_c | ha2_c;
  assign last_bit = (cnt_q == CNTW'(WIDTH - 1));

  // New sum bit enters at the MSB; works unchanged for WIDTH=1.
  always_comb begin
    part_shift            = part_q >> 1;
    part_shift[WIDTH-1]   = bit_s;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          part_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        part_d  = part_shift;
        carry_d = bit_c;
        cnt_d   = cnt_q + CNTW'(1);
        if (last_bit) begin
          sum_d   = part_shift;
          cout_d  = bit_c;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
